// File: rtl/ifu.sv
// ifu: PC holder, single-outstanding fetch, one-entry buffer toward decode.
// Ports: clk/rst_n, redirect_*_i, imem_req_*, imem_rsp_*_i, inst_*, pc_o, misalign_o.
// Option: `YSYX_23060251_IFU_MISALIGN_CHK_EN adds a TRAP state that presents
// misaligned redirect targets as a fault entry; otherwise targets are word-aligned.
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic        misalign_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef YSYX_23060251_IFU_MISALIGN_CHK_EN
  typedef enum logic [1:0] {REQ, WAIT, HOLD, TRAP} state_t;
`else
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pco_q, pco_d;
  logic [63:0] tgt;
  logic [31:0] inst_q, inst_d;
  logic        kill_q, kill_d;
  logic        vld_q, vld_d;

`ifdef YSYX_23060251_IFU_MISALIGN_CHK_EN
  logic mis_q, mis_d;
  logic trap_go;

  assign tgt = redirect_pc_i;

  // In WAIT a misaligned target only takes effect once the pending
  // response has been drained (same cycle, or later via kill).
  assign trap_go = (state_q == WAIT)
    ? imem_rsp_valid_i & (redirect_valid_i ? |tgt[1:0]
                                           : kill_q & |pc_q[1:0])
    : redirect_valid_i & |tgt[1:0];

  assign misalign_o = mis_q;
`else
  assign tgt        = redirect_pc_i & ~64'h3;
  assign misalign_o = 1'b0;
`endif

  assign imem_req_valid_o = (state_q == REQ) & ~redirect_valid_i;
  assign imem_req_addr_o  = pc_q;
  assign inst_valid_o     = vld_q;
  assign inst_o           = inst_q;
  assign pc_o             = pco_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      vld_q   <= 1'b0;
      inst_q  <= NOP;
      pco_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      vld_q   <= vld_d;
      inst_q  <= inst_d;
      pco_q   <= pco_d;
    end
  end

`ifdef YSYX_23060251_IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    pco_d   = pco_q;
    case (state_q)
      REQ: begin
        if (redirect_valid_i)      pc_d    = tgt;
        else if (imem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid_i) begin
          kill_d = 1'b0;
          if (redirect_valid_i) begin
            pc_d    = tgt;
            state_d = REQ;
          end else if (kill_q) begin
            state_d = REQ;
          end else begin
            inst_d  = imem_rsp_data_i;
            pco_d   = pc_q;
            state_d = HOLD;
          end
        end else if (redirect_valid_i) begin
          pc_d   = tgt;
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid_i) begin
          pc_d    = tgt;
          state_d = REQ;
        end else if (inst_ready_i) begin
          pc_d    = pc_q + 64'd4;
          state_d = REQ;
        end
      end
`ifdef YSYX_23060251_IFU_MISALIGN_CHK_EN
      TRAP: begin
        if (redirect_valid_i) begin
          pc_d    = tgt;
          state_d = REQ;
        end
      end
`endif
      default: state_d = REQ;
    endcase
`ifdef YSYX_23060251_IFU_MISALIGN_CHK_EN
    if (trap_go) begin
      state_d = TRAP;
      inst_d  = NOP;
      pco_d   = pc_d;
    end
    vld_d = (state_d == HOLD) | (state_d == TRAP);
    mis_d = (state_d == TRAP);
`else
    vld_d = (state_d == HOLD);
`endif
  end

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed protocol scenarios plus randomized traffic, every
// cycle compared against a transaction-level model of the fetch unit.
module tb_ifu;

`ifdef YSYX_23060251_IFU_MISALIGN_CHK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redir;
  logic [63:0] redir_pc;
  logic        req_valid;
  logic        req_rdy;
  logic [63:0] req_addr;
  logic        rsp_v;
  logic [31:0] rsp_d;
  logic        inst_valid;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        mis;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_rdy),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_v),
    .imem_rsp_data_i  (rsp_d),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_rdy),
    .inst_o           (inst),
    .pc_o             (pc),
    .misalign_o       (mis)
  );

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Model: architectural PC, whether a fetch is in flight and whether it
  // has been squashed, a one-slot queue of {inst, pc}, and a fault flag.
  logic [63:0] m_pc;
  bit          m_out, m_stale, m_trap;
  logic [95:0] m_buf[$];

  function automatic logic [63:0] fix(input logic [63:0] t);
    return MIS ? t : {t[63:2], 2'b00};
  endfunction

  task automatic go_to(input logic [63:0] t);
    m_pc = t;
    m_buf.delete();
    m_trap = MIS && (t[1:0] != 2'b00);
  endtask

  task automatic model_step();
    logic [63:0] t;
    if (!rst_n) begin
      m_pc = RST_PC; m_out = 0; m_stale = 0; m_trap = 0;
      m_buf.delete();
      return;
    end
    t = fix(redir_pc);
    if (m_trap || m_buf.size() != 0) begin
      if (redir) go_to(t);
      else if (!m_trap && inst_rdy) begin
        m_pc = m_pc + 64'd4;
        m_buf.delete();
      end
    end else if (m_out) begin
      if (rsp_v) begin
        m_out = 0;
        if (redir)        go_to(t);
        else if (m_stale) go_to(m_pc);
        else              m_buf.push_back({rsp_d, m_pc});
        m_stale = 0;
      end else if (redir) begin
        m_pc = t;
        m_stale = 1;
      end
    end else begin
      if (redir)        go_to(t);
      else if (req_rdy) m_out = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic erv;
      erv = !m_out && m_buf.size() == 0 && !m_trap && !redir;
      chk("m_req_valid", req_valid, erv);
      if (erv) chk("m_req_addr", req_addr, m_pc);
      chk("m_inst_valid", inst_valid, m_buf.size() != 0 || m_trap);
      chk("m_misalign", mis, m_trap);
      if (m_buf.size() != 0) begin
        chk("m_inst", inst, m_buf[0][95:64]);
        chk("m_pc", pc, m_buf[0][63:0]);
      end
      if (m_trap) begin
        chk("m_trap_inst", inst, 64'h13);
        chk("m_trap_pc", pc, m_pc);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    redir = 0; rsp_v = 0; inst_rdy = 0;
  endtask

  initial begin
    int cnt;
    rst_n = 0; redir = 0; redir_pc = '0; req_rdy = 0;
    rsp_v = 0; rsp_d = '0; inst_rdy = 0;
    nxt();
    smp();
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 64'h13);
    chk("rst_pc", pc, 0);
    chk("rst_mis", mis, 0);
    chk("rst_addr", req_addr, 64'h8000_0000);
    nxt();
    // cycle 0: first request
    rst_n = 1; req_rdy = 1;
    smp();
    chk("c0_req_valid", req_valid, 1);
    chk("c0_addr", req_addr, 64'h8000_0000);
    nxt();
    // cycle 1: response
    rsp_v = 1; rsp_d = 32'h0010_0093;
    smp();
    chk("c1_no_req", req_valid, 0);
    nxt();
    // cycles 2..6: decode stalls
    idle_in();
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", inst, 64'h0010_0093);
      chk("hold_pc", pc, 64'h8000_0000);
      chk("hold_no_req", req_valid, 0);
      nxt();
    end
    // cycle 7: consume
    inst_rdy = 1;
    smp();
    nxt();
    // cycle 8: next sequential request
    idle_in();
    smp();
    chk("c8_req_valid", req_valid, 1);
    chk("c8_addr", req_addr, 64'h8000_0004);
    nxt();
    // cycle 9: redirect while waiting, response 3 cycles later
    redir = 1; redir_pc = 64'h8000_0100;
    smp();
    nxt();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      rsp_v = (i == 2);
      rsp_d = 32'hDEAD_BEEF;
      smp();
      chk("kill_no_valid", inst_valid, 0);
      nxt();
    end
    // cycle 13: refetch from target
    idle_in();
    smp();
    chk("c13_inst_valid", inst_valid, 0);
    chk("c13_req_valid", req_valid, 1);
    chk("c13_addr", req_addr, 64'h8000_0100);
    nxt();
    rsp_v = 1; rsp_d = 32'h0000_0113;
    smp();
    nxt();
    // cycle 15: redirect in HOLD beats ready
    idle_in();
    redir = 1; redir_pc = 64'h8000_0200; inst_rdy = 1;
    smp();
    chk("c15_valid", inst_valid, 1);
    chk("c15_pc", pc, 64'h8000_0100);
    nxt();
    // cycles 16..19: memory not ready, redirect in cycle 17
    idle_in(); req_rdy = 0;
    smp();
    chk("c16_req_valid", req_valid, 1);
    chk("c16_addr", req_addr, 64'h8000_0200);
    nxt();
    redir = 1; redir_pc = 64'h8000_0300;
    smp();
    chk("c17_req_valid", req_valid, 0);
    nxt();
    idle_in();
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("c18_req_valid", req_valid, 1);
      chk("c18_addr", req_addr, 64'h8000_0300);
      nxt();
    end
    // cycle 20: misaligned redirect
    redir = 1; redir_pc = 64'h8000_0102;
    smp();
    nxt();
    idle_in(); inst_rdy = 1;
    smp();
    chk("mis_flag", mis, MIS);
    chk("mis_valid", inst_valid, MIS);
    chk("mis_req_valid", req_valid, !MIS);
    chk("mis_addr", req_addr,
        MIS ? 64'h8000_0102 : 64'h8000_0100);
    nxt();
    redir = 1; redir_pc = 64'h8000_0000;
    smp();
    nxt();
    // cycle 23: normal fetch again, then redirect to top of space
    idle_in();
    redir = 0;
    smp();
    chk("c23_req_valid", req_valid, 1);
    chk("c23_addr", req_addr, 64'h8000_0000);
    chk("c23_mis", mis, 0);
    redir = 1; redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    nxt();
    idle_in(); req_rdy = 1;
    smp();
    chk("wrap_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    nxt();
    rsp_v = 1; rsp_d = 32'h0000_0073;
    smp();
    nxt();
    idle_in(); inst_rdy = 1;
    smp();
    chk("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    nxt();
    idle_in();
    smp();
    chk("wrap_next", req_addr, 64'h0);
    nxt();
    // cycle 28: reset while a request is outstanding
    rst_n = 0; req_rdy = 0;
    smp();
    chk("mid_rst_valid", inst_valid, 0);
    chk("mid_rst_addr", req_addr, 64'h8000_0000);
    nxt();
    rst_n = 1; rsp_v = 1; rsp_d = 32'h1111_1111;
    smp();
    chk("stray_req", req_valid, 1);
    nxt();
    idle_in();
    smp();
    chk("stray_no_valid", inst_valid, 0);
    chk("stray_addr", req_addr, 64'h8000_0000);
    nxt();

    // Random traffic with a memory that answers 1..3 cycles after accept.
    cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rsp_v = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          rsp_v = 1;
          rsp_d = $urandom;
        end
      end
      redir = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0)
        redir_pc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      else
        redir_pc = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 4
                 + (($urandom_range(0, 3) == 0)
                    ? 64'($urandom_range(1, 3)) : 64'd0);
      req_rdy  = ($urandom_range(0, 3) != 0);
      inst_rdy = ($urandom_range(0, 2) != 0);
      smp();
      if (req_valid && req_rdy) cnt = $urandom_range(1, 3);
      nxt();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
